alu_sequencer: RTL and testbench

Program-driven instruction issuer that sits in front of the 16-bit accumulator ALU and drives its `opcode`/`input1`/`input2` interface. A host preloads a small instruction memory, pulses `start`, and the sequencer issues each instruction to the ALU, captures every ALU result, and optionally chains a result into the next instruction's `input1`. It is the initiator end of the ALU's opcode/operand interface.

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Program-driven instruction issuer for a 16-bit accumulator
//                ALU. A host loads a small instruction memory while the block
//                is idle, then pulses start. Each instruction is fetched,
//                driven onto the ALU opcode/operand interface, and the ALU
//                result is captured. A per-instruction chain bit substitutes
//                the last captured result for operand A.
//
//  Ports       : clk          rising-edge clock
//                clear        synchronous active-low reset
//                prog_we      instruction write strobe (IDLE only)
//                prog_addr    instruction write address
//                prog_data    {chain, opcode[3:0], A[W-1:0], B[W-1:0]}
//                run_len      instruction count, sampled on accepted start
//                start        run request (IDLE only)
//                alu_out      ALU combinational result
//                alu_opcode   registered opcode to ALU
//                alu_in1/2    registered operands to ALU
//                result       last captured ALU result
//                result_valid one-cycle pulse per captured result
//                pc           index of current instruction
//                busy         high from accepted start until back in IDLE
//                done         one-cycle pulse at end of run
//
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [2*W+4:0]   prog_data,
    input  logic [AW:0]      run_len,
    input  logic             start,
    input  logic [W-1:0]     alu_out,
    output logic [3:0]       alu_opcode,
    output logic [W-1:0]     alu_in1,
    output logic [W-1:0]     alu_in2,
    output logic [W-1:0]     result,
    output logic             result_valid,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             done
);

    localparam int          IW      = 2 * W + 5;
    localparam logic [AW:0] MAX_LEN = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] word;

    logic [AW:0]   len, len_n;
    logic [AW:0]   len_clamped;
    logic [AW-1:0] pc_n;
    logic [3:0]    opcode_n;
    logic [W-1:0]  in1_n, in2_n, result_n;
    logic          result_valid_n, busy_n, done_n;

    // Instruction memory: not reset, so a program survives a mid-run clear.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign word        = mem[pc];
    assign len_clamped = (run_len > MAX_LEN) ? MAX_LEN : run_len;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state        <= S_IDLE;
            len          <= '0;
            pc           <= '0;
            alu_opcode   <= 4'b0000;
            alu_in1      <= '0;
            alu_in2      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            len          <= len_n;
            pc           <= pc_n;
            alu_opcode   <= opcode_n;
            alu_in1      <= in1_n;
            alu_in2      <= in2_n;
            result       <= result_n;
            result_valid <= result_valid_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n        = state;
        len_n          = len;
        pc_n           = pc;
        opcode_n       = alu_opcode;
        in1_n          = alu_in1;
        in2_n          = alu_in2;
        result_n       = result;
        result_valid_n = 1'b0;
        busy_n         = busy;
        done_n         = 1'b0;

        case (state)
            S_IDLE: begin
                opcode_n = 4'b0000;
                if (start) begin
                    len_n   = len_clamped;
                    pc_n    = '0;
                    busy_n  = 1'b1;
                    state_n = (len_clamped != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                opcode_n = word[2*W+3:2*W];
                in2_n    = word[W-1:0];
                // Chain reads the result register as it stands now, i.e. the
                // previous instruction's (or previous run's) result.
                in1_n    = word[2*W+4] ? result : word[2*W-1:W];
                state_n  = S_ISSUE;
            end
            S_ISSUE: begin
                result_n       = alu_out;
                result_valid_n = 1'b1;
                if ({1'b0, pc} == len - (AW + 1)'(1)) begin
                    state_n = S_DONE;
                end else begin
                    pc_n    = pc + AW'(1);
                    state_n = S_FETCH;
                end
            end
            S_DONE: begin
                // DONE spans two cycles: the first raises done, the second
                // (while done is high) drops busy and returns to IDLE. start
                // is ignored throughout.
                opcode_n = 4'b0000;
                if (!done) begin
                    done_n = 1'b1;
                end else begin
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer with a small
//                combinational ALU stand-in (0001 add, 0010 sub, 0011 mul,
//                every other opcode returns 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int W  = 16;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            clear;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [2*W+4:0]  prog_data;
    logic [AW:0]     run_len;
    logic            start;
    logic [W-1:0]    alu_out;
    logic [3:0]      alu_opcode;
    logic [W-1:0]    alu_in1, alu_in2, result;
    logic            result_valid, busy, done;
    logic [AW-1:0]   pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] res_q[$];
    logic [31:0] op_q[$];
    logic [31:0] in1_q[$];
    int          rv_edges[$];
    int          done_edge, busy_low_edge;
    logic [31:0] e1_op, e1_in1, e1_in2;

    alu_sequencer #(.W(W), .DEPTH(16), .AW(AW)) dut (
        .clk          (clk),
        .clear        (clear),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .run_len      (run_len),
        .start        (start),
        .alu_out      (alu_out),
        .alu_opcode   (alu_opcode),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .result       (result),
        .result_valid (result_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            4'b0001: alu_out = alu_in1 + alu_in2;
            4'b0010: alu_out = alu_in1 - alu_in2;
            4'b0011: alu_out = alu_in1 * alu_in2;
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic prog(input int addr, input logic ch, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b);
        prog_we   = 1'b1;
        prog_addr = addr[AW-1:0];
        prog_data = {ch, op, a, b};
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Starts a run at the coming edge (edge 0) and samples after every edge.
    // disturb: second start + mem[0] write at edge 3. abort: clear during
    // the cycle after edge 3 (ISSUE of instruction 2).
    task automatic go(input logic [AW:0] len, input bit disturb, input bit abort);
        start   = 1'b1;
        run_len = len;
        @(negedge clk);
        start = 1'b0;
        res_q.delete(); op_q.delete(); in1_q.delete(); rv_edges.delete();
        done_edge = -1; busy_low_edge = -1;
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            if (e == 1) begin
                e1_op = 32'(alu_opcode); e1_in1 = 32'(alu_in1); e1_in2 = 32'(alu_in2);
            end
            if (result_valid) begin
                res_q.push_back(32'(result));
                op_q.push_back(32'(alu_opcode));
                in1_q.push_back(32'(alu_in1));
                rv_edges.push_back(e);
            end
            if (done && done_edge < 0) done_edge = e;
            if (!busy) begin busy_low_edge = e; break; end
            start   = 1'b0;
            prog_we = 1'b0;
            clear   = 1'b1;
            if (disturb && e == 3) begin
                start     = 1'b1;
                run_len   = 5'd1;
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = {1'b0, 4'b0001, 16'd100, 16'd100};
            end
            if (abort && e == 3) clear = 1'b0;
        end
        start = 1'b0; prog_we = 1'b0; clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        run_len = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_opcode", 32'(alu_opcode), 0);
        check("rst_in1", 32'(alu_in1), 0);
        check("rst_in2", 32'(alu_in2), 0);
        check("rst_result", 32'(result), 0);
        check("rst_ctrl", {28'd0, result_valid, busy, done, 1'b0}, 0);
        check("rst_pc", 32'(pc), 0);
        clear = 1'b1;
        @(negedge clk);

        // Single instruction; program write in the same cycle as start.
        prog_we = 1'b1; prog_addr = '0; prog_data = {1'b0, 4'b0001, 16'd1, 16'd1};
        go(5'd1, 1'b0, 1'b0);
        check("t1_op_e1", e1_op, 1);
        check("t1_in1_e1", e1_in1, 1);
        check("t1_in2_e1", e1_in2, 1);
        check("t1_nres", res_q.size(), 1);
        check("t1_res", qget(res_q, 0), 2);
        check("t1_rv_edge", rv_edges.size() > 0 ? rv_edges[0] : -1, 2);
        check("t1_done_edge", done_edge, 3);
        check("t1_busy_low", busy_low_edge, 4);
        check("t1_op_idle", 32'(alu_opcode), 0);

        // Chained run.
        prog(0, 1'b0, 4'b0001, 16'd3, 16'd4);
        prog(1, 1'b1, 4'b0011, 16'hAAAA, 16'd5);
        prog(2, 1'b1, 4'b0010, 16'h5555, 16'd10);
        go(5'd3, 1'b0, 1'b0);
        check("ch_nres", res_q.size(), 3);
        check("ch_res0", qget(res_q, 0), 7);
        check("ch_res1", qget(res_q, 1), 35);
        check("ch_res2", qget(res_q, 2), 25);
        check("ch_in1_1", qget(in1_q, 1), 7);
        check("ch_rv_gap", rv_edges.size() == 3 ? rv_edges[2] - rv_edges[0] : -1, 4);
        check("ch_pc", 32'(pc), 2);
        check("ch_done_edge", done_edge, 7);

        // Zero-length run.
        go(5'd0, 1'b0, 1'b0);
        check("z_nres", res_q.size(), 0);
        check("z_done_edge", done_edge, 1);
        check("z_busy_low", busy_low_edge, 2);
        check("z_op_e1", e1_op, 0);
        check("z_in1_keep", 32'(alu_in1), 35);
        check("z_in2_keep", 32'(alu_in2), 10);

        // Start and program write during a run are ignored.
        prog(0, 1'b0, 4'b0001, 16'd1, 16'd2);
        prog(1, 1'b1, 4'b0001, 16'h0, 16'd3);
        prog(2, 1'b1, 4'b0011, 16'h0, 16'd2);
        prog(3, 1'b1, 4'b0010, 16'h0, 16'd5);
        go(5'd4, 1'b1, 1'b0);
        check("d_nres", res_q.size(), 4);
        check("d_res0", qget(res_q, 0), 3);
        check("d_res1", qget(res_q, 1), 6);
        check("d_res2", qget(res_q, 2), 12);
        check("d_res3", qget(res_q, 3), 7);
        check("d_busy_low", busy_low_edge, 10);
        go(5'd1, 1'b0, 1'b0);
        check("d_mem0_kept", qget(res_q, 0), 3);

        // Clear during ISSUE of instruction 2.
        go(5'd4, 1'b0, 1'b1);
        check("a_nres", res_q.size(), 1);
        check("a_no_done", done_edge, -1);
        check("a_busy_low", busy_low_edge, 4);
        check("a_op", 32'(alu_opcode), 0);
        check("a_in", {alu_in1, alu_in2}, 0);
        check("a_result", 32'(result), 0);
        check("a_pc", 32'(pc), 0);
        go(5'd4, 1'b0, 1'b0);
        check("a_rerun_n", res_q.size(), 4);
        check("a_rerun_r1", qget(res_q, 1), 6);
        check("a_rerun_r3", qget(res_q, 3), 7);

        // Opcode pass-through.
        prog(0, 1'b0, 4'b1111, 16'h0800, 16'h0);
        prog(1, 1'b0, 4'b1000, 16'hFFFF, 16'h0);
        go(5'd2, 1'b0, 1'b0);
        check("p_op0", qget(op_q, 0), 4'hF);
        check("p_op1", qget(op_q, 1), 4'h8);
        check("p_res0", qget(res_q, 0), 0);
        check("p_res1", qget(res_q, 1), 0);
        check("p_op_idle", 32'(alu_opcode), 0);

        // run_len beyond DEPTH clamps to 16 instructions.
        go(5'd31, 1'b0, 1'b0);
        check("cl_nres", res_q.size(), 16);
        check("cl_busy_low", busy_low_edge, 34);
        check("cl_pc", 32'(pc), 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
